grocery_checkout: RTL and testbench

GROCERY_CHECKOUT -- requirements
Module: grocery_checkout

---
 rtl/grocery_checkout_pkg.sv | 24 ++
 rtl/grocery_checkout_debouncer.sv | 47 ++++
 rtl/grocery_checkout.sv | 159 +++++++++++++++
 tb/tb_grocery_checkout.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grocery_checkout_pkg.sv
// grocery_checkout_pkg
//   Shared definitions for the grocery checkout block: the controller state
//   encoding, the coin denominations used when handing out change, and the
//   pay-button debounce length.
package grocery_checkout_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Denominations, largest first; change is paid out greedily from these.
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_2  = 2;
  localparam int unsigned COIN_1  = 1;

  // Number of consecutive synchronised samples that must disagree with the
  // clean output before the debouncer accepts the new level.
  localparam int unsigned DEBOUNCE_LEN = 4;

endpackage

// File: rtl/grocery_checkout_debouncer.sv
// grocery_checkout_debouncer
//   Two-flop synchroniser followed by a stability counter. clean_out follows
//   noisy_in only after the synchronised input has differed from clean_out
//   for LEN consecutive cycles; shorter glitches are ignored.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset (clears synchroniser, counter,
//               output)
//   noisy_in  - raw asynchronous button level
//   clean_out - debounced level
module grocery_checkout_debouncer
  import grocery_checkout_pkg::*;
#(
  parameter int unsigned LEN = DEBOUNCE_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy_in,
  output logic clean_out
);

  localparam int unsigned CNT_W = $clog2(LEN) + 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b00;
      cnt       <= '0;
      clean_out <= 1'b0;
    end else begin
      sync <= {sync[0], noisy_in};
      // Any sample that agrees with the current output restarts the count,
      // so only an uninterrupted run of LEN differing samples flips it.
      if (sync[1] == clean_out) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(LEN - 1)) begin
        clean_out <= sync[1];
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/grocery_checkout.sv
// grocery_checkout
//   Checkout controller: loads a bill, collects payments from a debounced
//   pay button, then dispenses change one coin per cycle (greedy over
//   10/5/2/1). All outputs are registered.
// Build option:
//   GROCERY_CHECKOUT_CANCEL_EN - adds the cancel input, which refunds what
//   has been paid so far while collecting.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   total      - bill amount, sampled when start is seen in IDLE/DONE
//   start      - load strobe (level, ignored while busy)
//   inp        - payment value for the current pay press
//   pay        - raw pay push-button
//   cancel     - (option only) refund request while collecting
//   due        - amount still owed
//   change     - change not yet dispensed
//   coin_out   - coin dispensed this cycle, valid with coin_valid
//   coin_valid - dispense strobe, high for each coin cycle
//   busy       - high in COLLECT and DISPENSE
//   done       - high in DONE
module grocery_checkout
  import grocery_checkout_pkg::*;
#(
  parameter int unsigned TOTAL_W = 8,
  parameter int unsigned COIN_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TOTAL_W-1:0] total,
  input  logic               start,
  input  logic [COIN_W-1:0]  inp,
  input  logic               pay,
`ifdef GROCERY_CHECKOUT_CANCEL_EN
  input  logic               cancel,
`endif
  output logic [TOTAL_W-1:0] due,
  output logic [TOTAL_W-1:0] change,
  output logic [COIN_W-1:0]  coin_out,
  output logic               coin_valid,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] due_d, change_d;
  logic [COIN_W-1:0]  coin_out_d;
  logic               coin_valid_d, busy_d, done_d;
  logic               pay_clean, pay_prev, pay_evt;
  logic [TOTAL_W-1:0] inp_ext;

`ifdef GROCERY_CHECKOUT_CANCEL_EN
  logic [TOTAL_W-1:0] total_lat_q, total_lat_d;
`endif

  grocery_checkout_debouncer u_pay_db (
    .clk       (clk),
    .rst       (rst),
    .noisy_in  (pay),
    .clean_out (pay_clean)
  );

  assign pay_evt = pay_clean & ~pay_prev;
  assign inp_ext = {{(TOTAL_W - COIN_W){1'b0}}, inp};

  function automatic logic [TOTAL_W-1:0] pick_coin(input logic [TOTAL_W-1:0] amt);
    if (amt >= TOTAL_W'(COIN_10))     return TOTAL_W'(COIN_10);
    else if (amt >= TOTAL_W'(COIN_5)) return TOTAL_W'(COIN_5);
    else if (amt >= TOTAL_W'(COIN_2)) return TOTAL_W'(COIN_2);
    else if (amt >= TOTAL_W'(COIN_1)) return TOTAL_W'(COIN_1);
    else                              return '0;
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    due_d    = due;
    change_d = change;
`ifdef GROCERY_CHECKOUT_CANCEL_EN
    total_lat_d = total_lat_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          due_d    = total;
          change_d = '0;
`ifdef GROCERY_CHECKOUT_CANCEL_EN
          total_lat_d = total;
`endif
          state_d  = (total == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
`ifdef GROCERY_CHECKOUT_CANCEL_EN
        if (cancel) begin
          change_d = total_lat_q - due;
          due_d    = '0;
          state_d  = (change_d == '0) ? DONE : DISPENSE;
        end else
`endif
        if (pay_evt && inp_ext != '0) begin
          if (inp_ext < due) begin
            due_d = due - inp_ext;
          end else begin
            change_d = inp_ext - due;
            due_d    = '0;
            state_d  = (change_d == '0) ? DONE : DISPENSE;
          end
        end
      end
      DISPENSE: begin
        change_d = change - pick_coin(change);
        if (change_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they line up with it once
    // registered: the coin shown during a DISPENSE cycle is the one taken
    // off change at the end of that cycle, and nothing is shown in DONE.
    coin_valid_d = (state_d == DISPENSE);
    coin_out_d   = coin_valid_d ? COIN_W'(pick_coin(change_d)) : '0;
    busy_d       = (state_d == COLLECT) || (state_d == DISPENSE);
    done_d       = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      due        <= '0;
      change     <= '0;
      coin_out   <= '0;
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pay_prev   <= 1'b0;
`ifdef GROCERY_CHECKOUT_CANCEL_EN
      total_lat_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      due        <= due_d;
      change     <= change_d;
      coin_out   <= coin_out_d;
      coin_valid <= coin_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      pay_prev   <= pay_clean;
`ifdef GROCERY_CHECKOUT_CANCEL_EN
      total_lat_q <= total_lat_d;
`endif
    end
  end

endmodule

// File: tb/tb_grocery_checkout.sv
// tb_grocery_checkout
//   Directed and randomised bench for grocery_checkout (default build).
//   Expected values come from a press-level model of the checkout rules.
module tb_grocery_checkout;

  localparam int HOLD = 12;
  localparam int REL  = 12;

  logic       clk = 1'b0;
  logic       rst, start, pay;
  logic [7:0] total;
  logic [3:0] inp;
  logic [7:0] due, change;
  logic [3:0] coin_out;
  logic       coin_valid, busy, done;

  always #5 clk = ~clk;

  grocery_checkout dut (
    .clk        (clk),
    .rst        (rst),
    .total      (total),
    .start      (start),
    .inp        (inp),
    .pay        (pay),
    .due        (due),
    .change     (change),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .busy       (busy),
    .done       (done)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Coin monitor: records every dispensed coin with the change shown and
  // the cycle it appeared in.
  int coin_q[$];
  int chg_q[$];
  int cyc_q[$];

  always @(negedge clk) begin
    if (coin_valid === 1'b1) begin
      coin_q.push_back(int'(coin_out));
      chg_q.push_back(int'(change));
      cyc_q.push_back(cycle);
      check("done_low_while_dispensing", {31'd0, done}, 32'd0);
    end
  end

  // Press-level reference model.
  int m_due;
  int m_change;
  bit m_collect;
  int exp_coins[$];

  function automatic void build_coins(input int c);
    int denoms[4] = '{10, 5, 2, 1};
    exp_coins.delete();
    while (c > 0) begin
      foreach (denoms[i]) begin
        if (denoms[i] <= c) begin
          exp_coins.push_back(denoms[i]);
          c -= denoms[i];
          break;
        end
      end
    end
  endfunction

  function automatic void model_start(input int t);
    m_due     = t;
    m_change  = 0;
    m_collect = (t != 0);
    exp_coins.delete();
  endfunction

  function automatic void model_pay(input int v);
    if (m_collect && v != 0) begin
      if (v < m_due) begin
        m_due -= v;
      end else begin
        m_change  = v - m_due;
        m_due     = 0;
        m_collect = 0;
        build_coins(m_change);
        m_change  = 0;
      end
    end
  endfunction

  task automatic clear_mon();
    coin_q.delete();
    chg_q.delete();
    cyc_q.delete();
  endtask

  task automatic do_start(input int t);
    @(negedge clk);
    total = 8'(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input int v, input int hold);
    @(negedge clk);
    inp = 4'(v);
    pay = 1'b1;
    repeat (hold) @(negedge clk);
    pay = 1'b0;
    repeat (REL) @(negedge clk);
  endtask

  task automatic check_coins(input string tag);
    check({tag, "_count"}, coin_q.size(), exp_coins.size());
    for (int i = 0; i < coin_q.size() && i < exp_coins.size(); i++) begin
      check({tag, "_coin"}, coin_q[i], exp_coins[i]);
      check({tag, "_consecutive"}, cyc_q[i], cyc_q[0] + i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n_before;

    rst = 1'b1; start = 1'b0; pay = 1'b0; total = '0; inp = '0;
    repeat (3) @(negedge clk);
    check("rst_due", due, 0);
    check("rst_change", change, 0);
    check("rst_coin_valid", coin_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Exact payment, no change.
    clear_mon();
    do_start(23); model_start(23);
    check("exact_busy", busy, 1);
    check("exact_due_load", due, m_due);
    press(10, HOLD); model_pay(10); check("exact_due_1", due, m_due);
    press(10, HOLD); model_pay(10); check("exact_due_2", due, m_due);
    press(3, HOLD);  model_pay(3);
    check("exact_done", done, 1);
    check("exact_change", change, 0);
    check_coins("exact");

    // Change 8 -> 5, 2, 1.
    clear_mon();
    do_start(7); model_start(7);
    press(15, HOLD); model_pay(15);
    check_coins("chg");
    if (chg_q.size() > 0) check("chg_first_change", chg_q[0], 8);
    check("chg_done", done, 1);
    check("chg_change", change, 0);
    check("chg_busy", busy, 0);

    // Zero bill goes straight to DONE.
    clear_mon();
    do_start(0); model_start(0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("zero_busy_later", busy, 0);
    check("zero_coins", coin_q.size(), 0);

    // Long press counts once.
    clear_mon();
    do_start(20); model_start(20);
    press(4, 1000); model_pay(4);
    check("long_due", due, m_due);
    check("long_busy", busy, 1);

    // Bouncy press (single-cycle glitches around a clean hold) counts once.
    @(negedge clk);
    inp = 4'd4;
    for (int i = 0; i < 6; i++) begin pay = ~pay; @(negedge clk); end
    pay = 1'b1;
    repeat (HOLD) @(negedge clk);
    for (int i = 0; i < 6; i++) begin pay = ~pay; @(negedge clk); end
    pay = 1'b0;
    repeat (REL) @(negedge clk);
    model_pay(4);
    check("bounce_due", due, m_due);

    // start is ignored while collecting.
    do_start(99);
    check("start_ignored_due", due, m_due);

    // Reset in the middle of dispensing.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    clear_mon();
    do_start(1);
    @(negedge clk);
    inp = 4'd15; pay = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (coin_valid === 1'b1) found = 1;
    end
    check("rstd_coin_seen", found, 1);
    check("rstd_first_coin", coin_out, 10);
    check("rstd_first_change", change, 14);
    rst = 1'b1; pay = 1'b0;
    @(negedge clk);
    check("rstd_coin_valid", coin_valid, 0);
    check("rstd_coin_out", coin_out, 0);
    check("rstd_due", due, 0);
    check("rstd_change", change, 0);
    check("rstd_busy", busy, 0);
    check("rstd_done", done, 0);
    rst = 1'b0;
    n_before = coin_q.size();
    repeat (30) @(negedge clk);
    check("rstd_no_more_coins", coin_q.size(), n_before);

    // Randomised transactions.
    for (int t = 0; t < 6; t++) begin
      int bill;
      bill = $urandom_range(1, 60);
      clear_mon();
      do_start(bill); model_start(bill);
      check("rnd_due_load", due, m_due);
      for (int k = 0; k < 40 && m_collect; k++) begin
        int v;
        v = $urandom_range(0, 15);
        press(v, HOLD); model_pay(v);
        check("rnd_due", due, m_due);
      end
      check("rnd_done", done, !m_collect);
      check("rnd_change", change, 0);
      check_coins("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
